// File: rtl/median_window_gen.sv
// 3x3 sliding-window generator for raster video: two line buffers plus a
// column-shifted window register, one window per accepted pixel once row,col >= 2.
module median_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_pix,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] X1,
    output logic [7:0] X2,
    output logic [7:0] X3,
    output logic [7:0] X4,
    output logic [7:0] X5,
    output logic [7:0] X6,
    output logic [7:0] X7,
    output logic [7:0] X8,
    output logic [7:0] X9,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;

    logic             accept;
    logic             at_col_last;
    logic             at_row_last;
    logic             win_fire;

    logic [7:0]       lb1 [IMG_WIDTH];
    logic [7:0]       lb2 [IMG_WIDTH];
    logic [7:0]       lb1_rd;
    logic [7:0]       lb2_rd;

    logic [7:0]       win [9];

    // Backpressure is the only combinational path through the block.
    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;

    assign lb1_rd = lb1[cur_col];
    assign lb2_rd = lb2[cur_col];

    assign at_col_last = (cur_col == COL_LAST);
    assign at_row_last = (cur_row == ROW_LAST);
    assign win_fire    = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        nxt_col = cur_col + 1'b1;
        nxt_row = cur_row;
        if (at_col_last) begin
            nxt_col = '0;
            nxt_row = at_row_last ? '0 : cur_row + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (accept) begin
                col    <= nxt_col;
                row    <= nxt_row;
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb2_rd;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1_rd;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= in_pix;
            end
            if (win_fire) begin
                out_valid <= 1'b1;
                out_last  <= at_col_last && at_row_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // NOTE: line buffers are plain RAM with no reset; stale lines never reach a window
    // because windows start only at row 2, after both lines are rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= in_pix;
        end
    end

    assign X1 = win[0];
    assign X2 = win[1];
    assign X3 = win[2];
    assign X4 = win[3];
    assign X5 = win[4];
    assign X6 = win[5];
    assign X7 = win[6];
    assign X8 = win[7];
    assign X9 = win[8];

endmodule

// File: tb/tb_median_window_gen.sv
// Self-checking bench for median_window_gen on a 4x4 image: a frame-memory reference
// model checks every cycle, directed tables check the ramp windows per scenario.
module tb_median_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] x;
        logic        last;
    } win_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_pix;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;
    logic [7:0] X1, X2, X3, X4, X5, X6, X7, X8, X9;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    bit         mon_en   = 0;
    bit         rnd_done = 0;
    win_t       obs [$];

    // Reference model state: the current frame image plus the pending output window.
    logic [7:0]  img [H][W];
    bit          m_valid = 0;
    bit          m_last  = 0;
    logic [71:0] m_win   = '0;
    int          m_row   = 0;
    int          m_col   = 0;

    int ramp_win [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8, 9, 10},
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    median_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pix   (in_pix),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_ready (in_ready),
        .X1       (X1),
        .X2       (X2),
        .X3       (X3),
        .X4       (X4),
        .X5       (X5),
        .X6       (X6),
        .X7       (X7),
        .X8       (X8),
        .X9       (X9),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare against the model mid-cycle, then advance the model for the next edge.
    always @(negedge clk) begin
        logic [71:0] dut_win;
        win_t        t;
        int          r;
        int          c;
        bit          acc;
        bit          fire;
        dut_win = {X1, X2, X3, X4, X5, X6, X7, X8, X9};
        if (mon_en) begin
            checks++;
            assert (in_ready === (out_ready || !m_valid)) else begin
                errors++;
                $error("FAIL in_ready: got %b want %b", in_ready, (out_ready || !m_valid));
            end
            checks++;
            assert (out_valid === m_valid) else begin
                errors++;
                $error("FAIL out_valid: got %b want %b", out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                assert (dut_win === m_win) else begin
                    errors++;
                    $error("FAIL window: got %h want %h", dut_win, m_win);
                end
                checks++;
                assert (out_last === m_last) else begin
                    errors++;
                    $error("FAIL out_last: got %b want %b", out_last, m_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                t.x    = dut_win;
                t.last = out_last;
                obs.push_back(t);
            end
        end

        if (rst) begin
            m_valid = 0;
            m_last  = 0;
            m_win   = '0;
            m_row   = 0;
            m_col   = 0;
        end else begin
            acc  = (in_valid === 1'b1) && (out_ready || !m_valid);
            fire = 0;
            if (acc) begin
                r = in_sof ? 0 : m_row;
                c = in_sof ? 0 : m_col;
                img[r][c] = in_pix;
                fire = (r >= 2) && (c >= 2);
                if (fire) begin
                    m_win  = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                              img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                              img[r][c-2],   img[r][c-1],   img[r][c]};
                    m_last = (r == H - 1) && (c == W - 1);
                end
                c++;
                if (c == W) begin
                    c = 0;
                    r++;
                    if (r == H) r = 0;
                end
                m_row = r;
                m_col = c;
            end
            if (fire) m_valid = 1;
            else if (out_ready) m_valid = 0;
        end
    end

    function automatic logic [71:0] ramp_exp(input int k, input int off);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            v = {v[63:0], 8'(ramp_win[k][i] + off)};
        end
        return v;
    endfunction

    task automatic send(input logic [7:0] p, input logic sof);
        bit got;
        int n;
        in_pix   = p;
        in_sof   = sof;
        in_valid = 1'b1;
        got      = 0;
        n        = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL send_timeout: pixel %0d not accepted in %0d cycles, want accepted", p, n);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ramp(input int base, input bit sof, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            send(8'(base + i), sof && (i == 0));
            if (gaps) idle(1);
        end
    endtask

    task automatic check_count(input int n, input string tag);
        checks++;
        assert (obs.size() === n) else begin
            errors++;
            $error("FAIL %s: got %0d windows want %0d", tag, obs.size(), n);
        end
    endtask

    task automatic check_frame(input int idx, input int off, input string tag);
        for (int k = 0; k < 4; k++) begin
            if (idx + k < obs.size()) begin
                checks++;
                assert (obs[idx+k].x === ramp_exp(k, off)) else begin
                    errors++;
                    $error("FAIL %s_win%0d: got %h want %h", tag, k, obs[idx+k].x, ramp_exp(k, off));
                end
                checks++;
                assert (obs[idx+k].last === (k == 3)) else begin
                    errors++;
                    $error("FAIL %s_last%0d: got %b want %b", tag, k, obs[idx+k].last, (k == 3));
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, observed while rst is still held.
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++; $error("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        checks++;
        assert (out_last === 1'b0) else begin
            errors++; $error("FAIL rst_out_last: got %b want 0", out_last);
        end
        checks++;
        assert ({X1, X2, X3, X4, X5, X6, X7, X8, X9} === 72'h0) else begin
            errors++; $error("FAIL rst_window: got %h want 0", {X1, X2, X3, X4, X5, X6, X7, X8, X9});
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++; $error("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        rst    = 1'b0;
        mon_en = 1;

        // Ramp frame followed directly by a second frame without in_sof.
        obs.delete();
        ramp(0, 1, 0);
        ramp(100, 0, 0);
        idle(3);
        check_count(8, "wrap_count");
        check_frame(0, 0, "ramp");
        check_frame(4, 100, "wrap");

        // Backpressure: hold off the first window for 5 cycles.
        obs.delete();
        fork
            ramp(0, 1, 0);
            begin
                int k;
                k = 0;
                while (out_valid !== 1'b1 && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                checks++;
                assert (k < 100) else begin
                    errors++; $error("FAIL bp_wait: out_valid got %b after %0d cycles want 1", out_valid, k);
                end
                out_ready = 1'b0;
                #1;
                checks++;
                assert (in_ready === 1'b0) else begin
                    errors++; $error("FAIL bp_in_ready: got %b want 0", in_ready);
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);
        check_count(4, "bp_count");
        check_frame(0, 0, "bp");

        // Reset after pixel 9, then a ramp without in_sof.
        obs.delete();
        for (int i = 0; i < 10; i++) send(8'(i), i == 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ramp(0, 0, 0);
        idle(3);
        check_count(4, "rst_count");
        check_frame(0, 0, "rst");

        // Resync: in_sof arrives on the 7th pixel of a frame.
        obs.delete();
        for (int i = 0; i < 6; i++) send(8'(50 + i), 1'b0);
        ramp(20, 1, 0);
        idle(3);
        check_count(4, "resync_count");
        check_frame(0, 20, "resync");

        // in_valid low on alternate cycles.
        obs.delete();
        ramp(0, 1, 1);
        idle(3);
        check_count(4, "gap_count");
        check_frame(0, 0, "gap");

        // Random pixels, random gaps and random out_ready over three frames.
        obs.delete();
        rnd_done = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < 16; i++) begin
                        if ($urandom_range(0, 3) == 0) idle(1);
                        send(8'($urandom), (f == 0) && (i == 0));
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(4);
        check_count(12, "rand_count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/median_window_gen.md
MEDIAN_WINDOW_GEN -- requirements
Module: median_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (legal range 3..4096).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (legal range 3..4096).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_pix  input  8  raster-order pixel.
REQ-006 SHALL have port in_valid  input  1  in_pix valid.
REQ-007 SHALL have port in_sof  input  1  start of frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a pixel.
REQ-009 SHALL have ports X1..X9  output  8 each  3x3 window, row-major; X1 top-left, X5 centre, X9 bottom-right (newest pixel).
REQ-010 SHALL have port out_valid  output  1  X1..X9 hold a complete window.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the window.
REQ-012 SHALL have port out_last  output  1  window is the last of its frame; qualified by out_valid.

Function
REQ-013 SHALL accept a pixel on any cycle where in_valid && in_ready ("accept").
REQ-014 SHALL drive in_ready = out_ready || !out_valid, combinationally.
REQ-015 SHALL keep col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters giving the position of the next pixel to be accepted.
REQ-016 SHALL, on accept, advance col; at col=IMG_WIDTH-1, set col=0 and advance row; at row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, set row=0 and col=0 (frame wrap).
REQ-017 SHALL, on accept with in_sof=1, treat the pixel as (row 0, col 0) regardless of the counters, then continue with col=1, row=0.
REQ-018 SHALL keep two line buffers of IMG_WIDTH x 8 bits: LB1 holds line row-1 and LB2 holds line row-2, both indexed by col.
REQ-019 SHALL, on accept, read LB2[col] and LB1[col], write LB2[col]<=LB1[col] and LB1[col]<=in_pix, and shift the 3x3 window one column left, loading the new right column top-to-bottom with {LB2[col], LB1[col], in_pix}.
REQ-020 SHALL produce a window only for accepts where row>=2 and col>=2; no border padding; (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-021 SHALL assert out_valid in the cycle after a window-producing accept (latency 1 clk); out_valid SHALL stay 1 with X1..X9 and out_last stable until out_ready=1.
REQ-022 SHALL clear out_valid after an out_ready=1 cycle, unless the same cycle contains a window-producing accept, in which case out_valid stays 1 with the new window (back-to-back, 1 window/clk).
REQ-023 SHALL leave the window and line buffers unchanged on cycles without an accept.
REQ-024 SHALL assert out_last with the window of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-025 SHALL NOT let line-buffer contents from a previous frame or aborted frame reach any produced window; REQ-020 guarantees this.
REQ-026 SHALL contain no combinational path from in_valid to out_valid. The only combinational path is out_ready to in_ready.

Reset
REQ-027 SHALL, while rst=1, set out_valid=0, out_last=0, col=0, row=0, and window registers X1..X9=0; in_ready then equals 1.
REQ-028 SHALL NOT require line-buffer RAM contents to be cleared by reset.
REQ-029 SHALL, on reset mid-frame, discard any pending window; the next accepted pixel is (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4)
REQ-030 SHALL test the ramp: pixels 0..15 with in_valid=1 every cycle, in_sof on pixel 0, out_ready=1 -> exactly 4 windows, each 1 clk after pixels 10, 11, 14 and 15:
- {0,1,2,4,5,6,8,9,10}
- {1,2,3,5,6,7,9,10,11}
- {4,5,6,8,9,10,12,13,14}
- {5,6,7,9,10,11,13,14,15}, out_last=1 on this 4th window only.
REQ-031 SHALL test backpressure: ramp with out_ready=0 for 5 cycles after the first window -> in_ready=0, window {0,1,2,4,5,6,8,9,10} held stable, no pixels lost; the same 4 windows appear in order.
REQ-032 SHALL test frame wrap: a second frame of pixels 100..115 sent straight after the first, no in_sof -> windows equal the first frame's windows +100; no value <100 appears.
REQ-033 SHALL test reset mid-frame: rst for 1 clk after pixel 9, then ramp 0..15 -> no window from the aborted frame; the 4 windows of REQ-030 are produced.
REQ-034 SHALL test resync: in_sof asserted on the 7th pixel of a frame -> the counters restart; that pixel is (0,0), and the following 15 pixels yield the windows of REQ-030 offset by the pixel values sent.
REQ-035 SHALL test in_valid gaps: ramp with in_valid=0 on alternate cycles -> identical windows; out_valid pulses 1 clk each.
